// File: rtl/jtsdram_bank_chk_if.sv
// Request/response bundle between the bank exerciser and one SDRAM controller bank port.
// The exerciser drives the master side; the controller (or its model) drives the slave side.
interface jtsdram_bank_chk_if #(
  parameter int AW = 22,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          rdy;
  logic [DW-1:0] din;

  modport master (output req, we, addr, wdata, input ack, rdy, din);
  modport slave  (input req, we, addr, wdata, output ack, rdy, din);
endinterface

// File: rtl/jtsdram_bank_chk.sv
// SDRAM bank exerciser: one verify, fill or fill-then-verify pass over a bank region,
// using address-derived test data, with free / blanking-gated / random-gap request pacing.
module jtsdram_bank_chk #(
  parameter int          AW   = 22,
  parameter int          DW   = 16,
  parameter logic [15:0] SEED = 16'h5A3C,
  parameter int          TOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [1:0]         i_mode,
  input  logic               i_slow,
  input  logic               i_lvbl,
  jtsdram_bank_chk_if.master io_bus,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_bad,
  output logic [15:0]        o_err_cnt,
  output logic [AW-1:0]      o_first_bad,
  output logic               o_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [7:0]    TLAST    = 8'(TOUT - 1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t        r_state,     w_state;
  logic          r_phase,     w_phase;
  logic          r_mode2,     w_mode2;
  logic          r_slow,      w_slow;
  logic [AW-1:0] r_addr,      w_addr;
  logic [3:0]    r_gap,       w_gap;
  logic [7:0]    r_tcnt,      w_tcnt;
  logic          r_busy,      w_busy;
  logic          r_done,      w_done;
  logic          r_bad,       w_bad;
  logic [15:0]   r_err_cnt,   w_err_cnt;
  logic [AW-1:0] r_first_bad, w_first_bad;
  logic          r_timeout,   w_timeout;
  logic [15:0]   r_lfsr;
  logic          w_fin;
  logic          w_mismatch;
  logic [DW-1:0] w_pat;

  // Upper address bits above bit 15 fold into the low half; a 32-bit word carries the inverse on top.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    logic [15:0] lo;
    logic [31:0] full;
    lo      = 16'(a) ^ SEED ^ 16'(a >> 16);
    full    = {~lo, lo};
    pattern = full[DW-1:0];
  endfunction

  assign w_pat      = pattern(r_addr);
  assign w_mismatch = (io_bus.din != w_pat);

  assign io_bus.req   = (r_state == S_REQ);
  assign io_bus.we    = (r_state == S_REQ) && !r_phase;
  assign io_bus.addr  = r_addr;
  assign io_bus.wdata = ((r_state == S_REQ) && !r_phase) ? w_pat : '0;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_bad       = r_bad;
  assign o_err_cnt   = r_err_cnt;
  assign o_first_bad = r_first_bad;
  assign o_timeout   = r_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_mode2     <= 1'b0;
      r_slow      <= 1'b0;
      r_addr      <= '0;
      r_gap       <= 4'd0;
      r_tcnt      <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bad       <= 1'b0;
      r_err_cnt   <= 16'd0;
      r_first_bad <= '0;
      r_timeout   <= 1'b0;
      r_lfsr      <= 16'h0001;
    end else begin
      r_state     <= w_state;
      r_phase     <= w_phase;
      r_mode2     <= w_mode2;
      r_slow      <= w_slow;
      r_addr      <= w_addr;
      r_gap       <= w_gap;
      r_tcnt      <= w_tcnt;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_bad       <= w_bad;
      r_err_cnt   <= w_err_cnt;
      r_first_bad <= w_first_bad;
      r_timeout   <= w_timeout;
      r_lfsr      <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
    end
  end

  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase;
    w_mode2     = r_mode2;
    w_slow      = r_slow;
    w_addr      = r_addr;
    w_gap       = r_gap;
    w_tcnt      = r_tcnt;
    w_busy      = r_busy;
    w_done      = r_done;
    w_bad       = r_bad;
    w_err_cnt   = r_err_cnt;
    w_first_bad = r_first_bad;
    w_timeout   = r_timeout;
    w_fin       = 1'b0;

    case (r_state)
      S_GAP: begin
        if (r_slow ? (r_gap == 4'd0) : i_lvbl)
          w_state = S_REQ;
        else if (r_slow)
          w_gap = r_gap - 4'd1;
      end
      // A rdy arriving together with ack completes the access on the same edge.
      S_REQ: begin
        if (io_bus.ack) begin
          w_state = S_WAIT;
          w_tcnt  = 8'd0;
          w_fin   = io_bus.rdy;
        end
      end
      S_WAIT: begin
        if (io_bus.rdy) begin
          w_fin = 1'b1;
        end else if (r_tcnt == TLAST) begin
          w_timeout = 1'b1;
          w_bad     = 1'b1;
          w_busy    = 1'b0;
          w_done    = 1'b1;
          w_state   = S_DONE;
        end else begin
          w_tcnt = r_tcnt + 8'd1;
        end
      end
      default: ;
    endcase

    if (w_fin) begin
      if (r_phase && w_mismatch) begin
        if (r_err_cnt != 16'hFFFF)
          w_err_cnt = r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0)
          w_first_bad = r_addr;
        w_bad = 1'b1;
      end
      if (&r_addr) begin
        if (r_mode2 && !r_phase) begin
          w_phase = 1'b1;
          w_addr  = '0;
          w_gap   = r_lfsr[3:0];
          w_state = S_GAP;
        end else begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_DONE;
        end
      end else begin
        w_addr  = r_addr + ADDR_ONE;
        w_gap   = r_lfsr[3:0];
        w_state = S_GAP;
      end
    end

    // Start overrides whatever the pass was doing, including an access still in flight.
    if (i_start) begin
      w_err_cnt   = 16'd0;
      w_first_bad = '0;
      w_bad       = 1'b0;
      w_timeout   = 1'b0;
      w_done      = 1'b0;
      w_addr      = '0;
      w_phase     = !((i_mode == 2'd1) || (i_mode == 2'd2));
      w_mode2     = (i_mode == 2'd2);
      w_slow      = i_slow;
      w_busy      = 1'b1;
      w_gap       = r_lfsr[3:0];
      w_tcnt      = 8'd0;
      w_state     = S_GAP;
    end
  end

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// Bench for jtsdram_bank_chk: a responding bank model with corruption and rdy withholding,
// checked against pass-level expectations derived from the test data rule.
module tb_jtsdram_bank_chk;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int TOUT = 10;
  localparam int NW   = 16;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [1:0]    i_mode;
  logic          i_slow;
  logic          i_lvbl;
  logic          o_busy;
  logic          o_done;
  logic          o_bad;
  logic [15:0]   o_err_cnt;
  logic [AW-1:0] o_first_bad;
  logic          o_timeout;

  jtsdram_bank_chk_if #(.AW(AW), .DW(DW)) bus ();

  jtsdram_bank_chk #(.AW(AW), .DW(DW), .SEED(16'h5A3C), .TOUT(TOUT)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_mode      (i_mode),
    .i_slow      (i_slow),
    .i_lvbl      (i_lvbl),
    .io_bus      (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_bad       (o_bad),
    .o_err_cnt   (o_err_cnt),
    .o_first_bad (o_first_bad),
    .o_timeout   (o_timeout)
  );

  int            total;
  int            badCnt;
  logic [DW-1:0] mem [NW];
  logic [15:0]   corrupt;
  int            holdAddr;
  bit            holdHit;
  bit            stray;
  logic [1:0]    curMode;
  int            ackCount;
  int            writeCount;
  int            seqErr;
  int            weErr;
  int            wdErr;
  int            nextAddr;
  int            rdyDelay;
  int            ackEdge;
  int            cyc;
  int            viol;
  logic [AW-1:0] curAddr;
  logic          curWe;
  logic [DW-1:0] curData;
  logic          prevReq;
  logic          lvblAtEdge;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    lvblAtEdge <= i_lvbl;
  end

  // A request may only rise out of a cycle whose edge saw LVBL high (free pacing).
  initial begin
    prevReq = 1'b0;
    viol    = 0;
    forever begin
      @(negedge clk);
      if (bus.req === 1'b1 && prevReq === 1'b0 && lvblAtEdge === 1'b0 && i_slow === 1'b0)
        viol++;
      prevReq = bus.req;
    end
  end

  function automatic logic [DW-1:0] patRef(input logic [AW-1:0] a);
    logic [15:0] lo;
    lo = 16'(a) ^ 16'h5A3C;
    return {16'hFFFF - lo, lo};
  endfunction

  // Bank model: acks a request at once, completes it 1-3 cycles later.
  initial begin
    bus.ack  = 1'b0;
    bus.rdy  = 1'b0;
    bus.din  = '0;
    rdyDelay = 0;
    forever begin
      @(negedge clk);
      bus.ack = 1'b0;
      bus.rdy = 1'b0;
      if (stray) begin
        bus.ack  = 1'b1;
        bus.rdy  = 1'b1;
        bus.din  = 32'hDEAD_BEEF;
        stray    = 1'b0;
        rdyDelay = 0;
      end else begin
        if (rdyDelay > 0) begin
          rdyDelay--;
          if (rdyDelay == 0) begin
            bus.rdy = 1'b1;
            if (curWe) mem[curAddr] = curData;
            else       bus.din = mem[curAddr] ^ (corrupt[curAddr] ? 32'h0001_0001 : 32'h0);
          end
        end
        if (bus.req === 1'b1) begin
          bus.ack = 1'b1;
          ackCount++;
          curAddr = bus.addr;
          curWe   = bus.we;
          curData = bus.wdata;
          if (int'(curAddr) != nextAddr) seqErr++;
          nextAddr = (int'(curAddr) + 1) % NW;
          if (curWe) writeCount++;
          if (curWe !== ((curMode == 2'd1) || (curMode == 2'd2 && ackCount <= NW))) weErr++;
          if (curWe && curData !== patRef(curAddr)) wdErr++;
          if (int'(curAddr) == holdAddr) begin
            holdHit  = 1'b1;
            ackEdge  = cyc + 1;
            rdyDelay = 0;
          end else begin
            rdyDelay = $urandom_range(1, 3);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      badCnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic slow);
    @(negedge clk);
    #1;
    curMode = (mode == 2'd3) ? 2'd0 : mode;
    i_mode  = mode;
    i_slow  = slow;
    i_start = 1'b1;
    @(negedge clk);
    #1 i_start = 1'b0;
  endtask

  task automatic resetModel();
    ackCount   = 0;
    writeCount = 0;
    seqErr     = 0;
    weErr      = 0;
    wdErr      = 0;
    nextAddr   = 0;
    holdHit    = 1'b0;
    viol       = 0;
  endtask

  task automatic preload(input bit good);
    for (int a = 0; a < NW; a++)
      mem[a] = good ? patRef(AW'(a)) : DW'($urandom);
  endtask

  task automatic waitDone(input string tag, input int limit);
    int n;
    n = 0;
    while (o_done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " done"}, 32'(o_done), 32'd1);
  endtask

  task automatic verifyPass(input string tag, input logic [1:0] mode);
    int expErr;
    int expFirst;
    expErr   = 0;
    expFirst = 0;
    if (mode != 2'd1)
      for (int a = NW - 1; a >= 0; a--)
        if (corrupt[a]) begin
          expErr++;
          expFirst = a;
        end
    checkOutput({tag, " err_cnt"},   32'(o_err_cnt),   32'(expErr));
    checkOutput({tag, " first_bad"}, 32'(o_first_bad), 32'(expFirst));
    checkOutput({tag, " bad"},       32'(o_bad),       32'(expErr != 0));
    checkOutput({tag, " busy"},      32'(o_busy),      32'd0);
    checkOutput({tag, " timeout"},   32'(o_timeout),   32'd0);
    checkOutput({tag, " acks"},      32'(ackCount),    (mode == 2'd2) ? 32'd32 : 32'd16);
    checkOutput({tag, " writes"},    32'(writeCount),  (mode == 2'd1 || mode == 2'd2) ? 32'd16 : 32'd0);
    checkOutput({tag, " addr seq"},  32'(seqErr),      32'd0);
    checkOutput({tag, " we"},        32'(weErr),       32'd0);
    checkOutput({tag, " wdata"},     32'(wdErr),       32'd0);
  endtask

  initial begin
    int n;
    logic [1:0] rMode;
    logic       rSlow;
    total    = 0;
    badCnt   = 0;
    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_mode   = 2'd0;
    i_slow   = 1'b0;
    i_lvbl   = 1'b1;
    corrupt  = 16'h0;
    holdAddr = -1;
    stray    = 1'b0;
    curMode  = 2'd0;
    ackEdge  = 0;
    resetModel();

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    checkOutput("rst req",       32'(bus.req),     32'd0);
    checkOutput("rst we",        32'(bus.we),      32'd0);
    checkOutput("rst addr",      32'(bus.addr),    32'd0);
    checkOutput("rst wdata",     32'(bus.wdata),   32'd0);
    checkOutput("rst busy",      32'(o_busy),      32'd0);
    checkOutput("rst done",      32'(o_done),      32'd0);
    checkOutput("rst bad",       32'(o_bad),       32'd0);
    checkOutput("rst err_cnt",   32'(o_err_cnt),   32'd0);
    checkOutput("rst first_bad", 32'(o_first_bad), 32'd0);
    checkOutput("rst timeout",   32'(o_timeout),   32'd0);
    #1 rst_n = 1'b1;

    $display("[TB] clean verify pass");
    preload(1'b1);
    resetModel();
    applyStimulus(2'd0, 1'b0);
    checkOutput("start busy",    32'(o_busy),  32'd1);
    checkOutput("start req low", 32'(bus.req), 32'd0);
    @(negedge clk);
    checkOutput("first req",  32'(bus.req),  32'd1);
    checkOutput("first addr", 32'(bus.addr), 32'd0);
    checkOutput("first we",   32'(bus.we),   32'd0);
    waitDone("clean", 600);
    verifyPass("clean", 2'd0);

    $display("[TB] verify with corrupted words 5 and 9");
    preload(1'b1);
    corrupt = 16'h0220;
    resetModel();
    applyStimulus(2'd0, 1'b0);
    waitDone("corrupt", 600);
    verifyPass("corrupt", 2'd0);

    $display("[TB] fill-then-verify");
    preload(1'b0);
    corrupt = 16'h0;
    resetModel();
    applyStimulus(2'd2, 1'b0);
    waitDone("fillver", 1200);
    verifyPass("fillver", 2'd2);
    for (int a = 0; a < NW; a++)
      if (mem[a] !== patRef(AW'(a))) wdErr++;
    checkOutput("fillver mem", 32'(wdErr), 32'd0);

    $display("[TB] verify with LVBL toggling");
    preload(1'b1);
    resetModel();
    applyStimulus(2'd0, 1'b0);
    n = 0;
    while (o_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      #1 i_lvbl = ((n / 8) % 2) == 0;
      n++;
    end
    checkOutput("lvbl done", 32'(o_done), 32'd1);
    checkOutput("lvbl gate", 32'(viol),   32'd0);
    verifyPass("lvbl", 2'd0);
    #1 i_lvbl = 1'b1;

    $display("[TB] rdy timeout at address 3");
    preload(1'b1);
    resetModel();
    holdAddr = 3;
    applyStimulus(2'd0, 1'b0);
    waitDone("tout", 600);
    checkOutput("tout latency", 32'(cyc - ackEdge), 32'(TOUT));
    checkOutput("tout flag",    32'(o_timeout),     32'd1);
    checkOutput("tout bad",     32'(o_bad),         32'd1);
    checkOutput("tout addr",    32'(bus.addr),      32'd3);
    checkOutput("tout busy",    32'(o_busy),        32'd0);
    checkOutput("tout acks",    32'(ackCount),      32'd4);
    holdAddr = -1;

    $display("[TB] restart during WAIT at address 7");
    preload(1'b1);
    corrupt = 16'h0004;
    resetModel();
    holdAddr = 7;
    applyStimulus(2'd0, 1'b0);
    n = 0;
    while (!holdHit && n < 600) begin
      @(negedge clk);
      n++;
    end
    checkOutput("restart reached 7", 32'(holdHit), 32'd1);
    checkOutput("restart pre err",   32'(o_err_cnt), 32'd1);
    #1;
    corrupt  = 16'h0;
    holdAddr = -1;
    i_lvbl   = 1'b0;
    resetModel();
    applyStimulus(2'd0, 1'b0);
    checkOutput("restart busy",      32'(o_busy),      32'd1);
    checkOutput("restart err clr",   32'(o_err_cnt),   32'd0);
    checkOutput("restart bad clr",   32'(o_bad),       32'd0);
    checkOutput("restart first clr", 32'(o_first_bad), 32'd0);
    checkOutput("restart addr",      32'(bus.addr),    32'd0);
    checkOutput("restart req",       32'(bus.req),     32'd0);
    stray = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("stray req",  32'(bus.req),   32'd0);
    checkOutput("stray err",  32'(o_err_cnt), 32'd0);
    checkOutput("stray addr", 32'(bus.addr),  32'd0);
    #1 i_lvbl = 1'b1;
    waitDone("restart", 600);
    verifyPass("restart", 2'd0);

    $display("[TB] randomized passes");
    for (int it = 0; it < 5; it++) begin
      rMode   = 2'($urandom_range(0, 3));
      rSlow   = 1'($urandom_range(0, 1));
      corrupt = 16'($urandom & $urandom);
      preload(rMode == 2'd0 || rMode == 2'd3);
      resetModel();
      applyStimulus(rMode, rSlow);
      waitDone($sformatf("rand%0d", it), 3000);
      verifyPass($sformatf("rand%0d m%0d s%0d", it, rMode, rSlow), (rMode == 2'd3) ? 2'd0 : rMode);
    end

    $display("[TB] reset in the middle of a pass");
    preload(1'b0);
    corrupt = 16'h0;
    resetModel();
    applyStimulus(2'd2, 1'b1);
    repeat (40) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst req",  32'(bus.req),   32'd0);
    checkOutput("midrst busy", 32'(o_busy),    32'd0);
    checkOutput("midrst addr", 32'(bus.addr),  32'd0);
    checkOutput("midrst done", 32'(o_done),    32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post rst req",  32'(bus.req), 32'd0);
    checkOutput("post rst busy", 32'(o_busy),  32'd0);

    $display("test done: total=%0d bad=%0d", total, badCnt);
    $finish;
  end

endmodule
